// File: rtl/univ_shift_reg_param.sv
// univ_shift_reg_param: parametrised universal shift register with eight
// operating modes (hold, shr, shl, load, rotr, rotl, ashr, clear).
//
// Optional burst engine, built only when the macro USHREG_BURST_EN is
// defined. The engine runs a programmed number of shifts on its own and
// reports progress through busy_o and done_o. In the default build that
// macro is undefined: start_i and cnt_i are ignored, busy_o and done_o are
// tied low, and mode_i is applied on every edge. The port list is the same
// in both builds.
module univ_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] par_o,
    output logic             ser_r_o,
    output logic             ser_l_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_ASHR  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    logic [WIDTH-1:0] data;

    // Next register value for a given mode; serial fill bits enter at the
    // end opposite the shift direction. ashr replicates the sign bit, so
    // repeated ashr converges on all-sign fill.
    function automatic logic [WIDTH-1:0] next_value(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] cur,
        input logic             msb,
        input logic             lsb,
        input logic [WIDTH-1:0] load_val
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (mode)
            MODE_HOLD:  res = cur;
            MODE_SHR:   res = {msb, cur[WIDTH-1:1]};
            MODE_SHL:   res = {cur[WIDTH-2:0], lsb};
            MODE_LOAD:  res = load_val;
            MODE_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLEAR: res = '0;
            default:    res = cur;
        endcase
        return res;
    endfunction

    // Serial outputs are taps on the register, no extra latency.
    assign par_o   = data;
    assign ser_r_o = data[0];
    assign ser_l_o = data[WIDTH-1];

`ifdef USHREG_BURST_EN

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done;

    // Only the five shift modes may start a burst.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHR)  || (mode == MODE_SHL)  ||
               (mode == MODE_ROTR) || (mode == MODE_ROTL) ||
               (mode == MODE_ASHR);
    endfunction

    // Register, burst FSM, latched mode/count and the done pulse.
    // done is cleared every edge and set only on the edge that finishes
    // a burst (or accepts a zero-length one), giving a one-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            data   <= '0;
            mode_q <= MODE_HOLD;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && is_shift(mode_i)) begin
                        // Register holds on the start edge.
                        if (cnt_i == '0) begin
                            done <= 1'b1;
                        end else begin
                            mode_q <= mode_i;
                            cnt_q  <= cnt_i;
                            state  <= BUSY;
                        end
                    end else begin
                        data <= next_value(mode_i, data, msb_in, lsb_in, par_i);
                    end
                end
                BUSY: begin
                    // Serial fill bits are sampled live on each burst edge.
                    data <= next_value(mode_q, data, msb_in, lsb_in, par_i);
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state == BUSY);
    assign done_o = done;

`else

    // Burst inputs have no function in this build.
    logic unused_burst;
    assign unused_burst = ^{start_i, cnt_i};

    // Apply mode_i on every edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data <= '0;
        end else begin
            data <= next_value(mode_i, data, msb_in, lsb_in, par_i);
        end
    end

    assign busy_o = 1'b0;
    assign done_o = 1'b0;

`endif

endmodule

// File: doc/univ_shift_reg_param.md
# univ_shift_reg_param

Parametrised universal shift register with eight operating modes and an optional burst engine that performs a programmed number of shifts autonomously. It generalises the 4-bit hold/shift/load register to any width. It adds rotate, arithmetic-shift and clear modes and exposes serial outputs. It sits in the datapath wherever operands need serialising, alignment or multi-position shifting under control of a sequencer.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of burst count input
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- mode_i  in  3  operation select (see Operation)
- par_i  in  WIDTH  parallel load data
- msb_in  in  1  serial fill bit entering at MSB on shift right
- lsb_in  in  1  serial fill bit entering at LSB on shift left
- start_i  in  1  burst request (sampled when idle)
- cnt_i  in  CNT_W  burst shift count
- par_o  out  WIDTH  register contents
- ser_r_o  out  1  par_o[0], bit leaving on right shift
- ser_l_o  out  1  par_o[WIDTH-1], bit leaving on left shift
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse after final burst shift

## Operation
- Modes (mode_i):
  - 000: hold
  - 001: shr, {msb_in, A[W-1:1]}
  - 010: shl, {A[W-2:0], lsb_in}
  - 011: load par_i
  - 100: rotr, {A[0], A[W-1:1]}
  - 101: rotl, {A[W-2:0], A[W-1]}
  - 110: ashr, {A[W-1], A[W-1:1]}
  - 111: clear to 0
- FSM states: IDLE, BUSY.
- IDLE, start_i=0: mode_i applied every edge.
- IDLE, start_i=1, mode_i is a shift mode (001,010,100,101,110), cnt_i>0:
  - latch mode and count; register holds on that edge.
  - go to BUSY; busy_o=1.
- IDLE, start_i=1, cnt_i=0, shift mode: register holds; done_o pulses next cycle; stays IDLE.
- IDLE, start_i=1, non-shift mode: start ignored; mode_i applied normally.
- BUSY:
  - Each edge applies the latched shift and decrements remaining.
  - On the edge consuming the last count: return to IDLE, busy_o→0, done_o→1 for exactly one cycle.
  - mode_i, start_i, par_i ignored.
  - msb_in/lsb_in sampled live on each shift edge.
- cnt_i > WIDTH legal: shifts continue. Rotates wrap modulo WIDTH; shr/shl fill entirely with serial bits; ashr saturates to sign fill.
- Count is unsigned; maximum burst length is 2^CNT_W−1.

## Timing
- Reset values: par_o=0, busy_o=0, done_o=0, FSM=IDLE, latched count=0.
- Reset asserted mid-burst aborts immediately (asynchronously): outputs go to reset values and no done_o pulse is issued.
- Single-mode latency: result visible on par_o one edge after mode_i is sampled.
- Burst of N: start edge, then N shift edges.
  - busy_o high for N cycles, starting the cycle after the start edge.
  - done_o high during the cycle after the Nth shift edge, coincident with busy_o low.
- Back-to-back bursts: start_i may be asserted in the done_o cycle and is accepted.
- ser_r_o/ser_l_o are combinational from par_o, with no added latency.

## Configuration
- Macro USHREG_BURST_EN.
- Defined: burst engine, FSM, busy_o and done_o behave as above.
- Undefined:
  - start_i and cnt_i are ignored; FSM is not built.
  - busy_o and done_o are tied 0.
  - mode_i is applied every cycle.
  - The port list is unchanged.

## Test plan
- Reset: assert rst_i mid-cycle with par_o=0x5A → par_o=0x00, busy_o=0, done_o=0 without waiting for a clock edge.
- Modes, WIDTH=8:
  - load 0xA5, then rotr → 0xD2.
  - reload 0xA5, then rotl → 0x4B.
  - shl with lsb_in=1 from 0xA5 → 0x4B.
  - clear → 0x00.
- ashr: load 0x90, ashr twice → 0xC8 then 0xE4. Hold for 3 cycles → stays 0xE4.
- Burst: load 0x81; start_i=1, mode=101, cnt=3 → busy_o high 3 cycles, par_o=0x0C, one done_o pulse. mode_i toggled during burst has no effect.
- Edges:
  - start with cnt=0 → par_o unchanged, done_o pulse next cycle, busy_o stays 0.
  - start with mode=011 → plain load, no busy_o.
  - rst_i during burst → par_o=0, no done_o.
- Macro undefined: start_i=1, mode=001, cnt=5, msb_in=1 on 0x00 → single shift per edge (0x80 after first edge); busy_o and done_o stay 0.
